// File: rtl/addsub_seq.sv
// addsub_seq: digit-serial adder/subtractor with registered C/V/N/Z flags.
// Processes D bits per clock, LSB digit first, W/D digit clocks per operation.
// Supports ADC/SBC chaining through the stored C and Z flags.
module addsub_seq #(
    parameter int unsigned W = 16,
    parameter int unsigned D = 4
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         START,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         M,
    input  logic         CIN_EN,
    output logic         BUSY,
    output logic         DONE,
    output logic [W-1:0] S,
    output logic         C,
    output logic         V,
    output logic         N,
    output logic         Z
);

    localparam int unsigned L    = W / D;
    localparam int unsigned CntW = (L > 1) ? $clog2(L) : 1;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;       // already inverted for subtract
    logic            cy_q, cy_d;     // running digit carry
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            cin_en_q, cin_en_d;
    logic [W-1:0]    res_q, res_d;   // internal result shift register
    logic [W-1:0]    s_q, s_d;       // architecturally visible result
    logic            c_q, c_d;
    logic            v_q, v_d;
    logic            z_q, z_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [D-1:0]    a_dig, b_dig;
    logic [D:0]      dig_sum;
    logic            carry_into_msb;
    logic [W-1:0]    a_shift, b_shift, res_shift;
    logic            last_digit;

    // Digit adder and shift-register advance for the current digit
    always_comb begin
        a_dig          = a_q[D-1:0];
        b_dig          = b_q[D-1:0];
        dig_sum        = {1'b0, a_dig} + {1'b0, b_dig} + {{D{1'b0}}, cy_q};
        // Carry into the top bit of this digit; only meaningful on the final digit
        carry_into_msb = dig_sum[D-1] ^ a_dig[D-1] ^ b_dig[D-1];
        a_shift        = W'({{D{1'b0}}, a_q} >> D);
        b_shift        = W'({{D{1'b0}}, b_q} >> D);
        // New sum digit enters from the MSB end so the LSB digit ends up at bit 0
        res_shift      = W'({dig_sum[D-1:0], res_q} >> D);
        last_digit     = (cnt_q == CntW'(L - 1));
    end

    // Next-state for the control FSM, datapath registers and flags
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cy_d     = cy_q;
        cnt_d    = cnt_q;
        cin_en_d = cin_en_q;
        res_d    = res_q;
        s_d      = s_q;
        c_d      = c_q;
        v_d      = v_q;
        z_d      = z_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (START) begin
                    state_d  = StRun;
                    a_d      = A;
                    b_d      = B ^ {W{M}};
                    // Chained words take the stored carry (or no-borrow) flag
                    cy_d     = CIN_EN ? c_q : M;
                    cin_en_d = CIN_EN;
                    cnt_d    = '0;
                    res_d    = '0;
                    busy_d   = 1'b1;
                end
            end
            StRun: begin
                a_d   = a_shift;
                b_d   = b_shift;
                cy_d  = dig_sum[D];
                cnt_d = cnt_q + CntW'(1);
                res_d = res_shift;
                if (last_digit) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    s_d     = res_shift;
                    c_d     = dig_sum[D];
                    v_d     = dig_sum[D] ^ carry_into_msb;
                    // Multi-word zero: every word of the chain must be zero
                    z_d     = (res_shift == '0) & (cin_en_q ? z_q : 1'b1);
                end
            end
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            cy_q     <= 1'b0;
            cnt_q    <= '0;
            cin_en_q <= 1'b0;
            res_q    <= '0;
            s_q      <= '0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cy_q     <= cy_d;
            cnt_q    <= cnt_d;
            cin_en_q <= cin_en_d;
            res_q    <= res_d;
            s_q      <= s_d;
            c_q      <= c_d;
            v_q      <= v_d;
            z_q      <= z_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign S    = s_q;
    assign C    = c_q;
    assign V    = v_q;
    assign N    = s_q[W-1];
    assign Z    = z_q;

endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
- Parametrised digit-serial adder/subtractor with registered C/V/N/Z flags and a START/DONE handshake.
- Processes D bits per clock, LSB digit first.
- Supports chained multi-word arithmetic (ADC/SBC) through the stored carry and zero flags.
- Sits beside the combinational add/sub datapath as the area-reduced, wide-operand arithmetic unit for the ALU.

Parameters:
- W, 16: operand/result width in bits.
- D, 4: digit width processed per clock. W must be an integer multiple of D; D = W gives a single-cycle operation.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  synchronous active-low reset.
- START  input  1  request; sampled only when BUSY=0.
- A  input  W  operand A; captured at accepted START.
- B  input  W  operand B; captured at accepted START.
- M  input  1  0 = A+B, 1 = A-B (A + ~B + carry-in); captured at START.
- CIN_EN  input  1  0 = carry-in is M; 1 = carry-in is the stored C flag (chained word). Captured at START.
- BUSY  output  1  operation in progress.
- DONE  output  1  one-cycle completion pulse.
- S  output  W  registered result.
- C  output  1  carry out of MSB (for subtract: 1 = no borrow).
- V  output  1  signed overflow (carry into MSB XOR carry out of MSB).
- N  output  1  S[W-1].
- Z  output  1  zero flag (chained, see below).

Behaviour:
- Clocking and reset: one clock, CLK. Reset is synchronous and active-low on RST_N. While RST_N=0 at a rising edge: state goes to IDLE; BUSY=0, DONE=0, S=0, C=0, V=0, N=0, Z=0; the digit counter and internal shift registers clear.
- Reset mid-operation aborts the operation. No DONE is produced and the previous S/flags are lost (zeroed).
- L = W/D clocks of latency.
- FSM IDLE -> RUN:
  - Taken at an edge where START=1 and BUSY=0.
  - At that edge, latch A, B XOR {W{M}}, M and CIN_EN.
  - Carry register loads M if CIN_EN=0, else the current C output.
  - Digit counter loads 0; BUSY=1 from the next cycle.
- RUN, each edge:
  - Add the low D bits of the A/B shift registers plus the carry register.
  - Shift the sum digit into the result register from the MSB end.
  - Update carry; increment the counter.
  - On the final digit (counter = L-1), also capture carry-into-MSB for V.
- Completion, at the edge processing digit L-1:
  - S, C, V, N and Z update.
  - DONE=1 and BUSY=0 for the following cycle, then the FSM returns to IDLE.
  - If START=1 is sampled during the DONE cycle, it is accepted (back-to-back operation, no bubble).
- S and flags hold their values between completions. Intermediate digits are never visible on S.
- START while BUSY=1 is ignored: no queuing, and the in-flight operands are unaffected.
- Z = (result == 0) AND (CIN_EN ? previous Z : 1). A chained multi-word result therefore reports zero only if all words are zero.
- C for subtract follows the two's-complement convention: 1 = no borrow. SBC chaining therefore uses C directly as carry-in.
- Operand inputs may change freely after the START edge.
- All arithmetic is modulo 2^W. There are no saturation modes.

Test Plan:
- W=16, D=4; apply RST_N=0 for 2 cycles during RUN (2 digits done) -> BUSY=0, DONE never pulses, S=0x0000 and C/V/N/Z=0 on the cycle after reset.
- A=0x7FFF, B=0x0001, M=0, CIN_EN=0 -> DONE exactly 4 clocks after START; S=0x8000, C=0, V=1, N=1, Z=0.
- A=0x1234, B=0x1234, M=1 -> S=0x0000, C=1, V=0, N=0, Z=1.
- A=0x0000, B=0x0001, M=1 -> S=0xFFFF, C=0, V=0, N=1, Z=0; then A=0x8000, B=0x0001, M=1 -> S=0x7FFF, C=1, V=1, N=0.
- Chained 32-bit add:
  - Low word: A=0xFFFF, B=0x0001, CIN_EN=0 -> S=0x0000, C=1, Z=1.
  - High word: A=0x0000, B=0x0000, CIN_EN=1 -> S=0x0001, C=0, Z=0.
  - Repeat with high-word inputs 0xFFFF+0x0000 -> S=0x0000, C=1, Z=1.
- START held high continuously (operands change every cycle):
  - Only operands present at accepted edges are used.
  - DONE pulses every 4 clocks; BUSY is never low for more than the DONE cycle.
  - Repeat with D=16: DONE the cycle after START.
